// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiplier / divider with one shared 64-bit working register.
// Define MULTDIV_BOOTH_EN to use a 16-step radix-4 Booth multiply instead of 32-step shift-add.
module multdiv_iter (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StMult, StDiv, StDone} state_e;

`ifdef MULTDIV_BOOTH_EN
  localparam logic [5:0] MulTerm = 6'd16;
`else
  localparam logic [5:0] MulTerm = 6'd32;
`endif
  localparam logic [5:0] DivTerm = 6'd32;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] op_q, op_d;
  logic        sign_q, sign_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;
`ifdef MULTDIV_BOOTH_EN
  logic        booth_q, booth_d;
`endif

  logic        start_mul, start_div, last;
  logic [63:0] mul_next, div_next;
  logic        mul_ovf;
  logic [31:0] abs_a, abs_b, quot_s;
  logic        div_zero, div_ovf;

  assign start_mul = ctrl_MULT & ~ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;
  assign last      = (state_q == StMult) ? (cnt_q == MulTerm) : (cnt_q == DivTerm);

  assign abs_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign abs_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

  // Product fits in 32 signed bits only when bits 63..31 are all equal.
  assign mul_ovf = ~((&prod_q[63:31]) | ~(|prod_q[63:31]));

  assign quot_s   = sign_q ? (32'd0 - prod_q[31:0]) : prod_q[31:0];
  assign div_zero = (op_q == 32'd0);
  // Magnitude quotient is at most 2^31; only a positive 2^31 is unrepresentable.
  assign div_ovf  = ~sign_q & prod_q[31];

  // ---------------------------------------------------------------------------
  // Multiply step: prod_q = {partial high, remaining multiplier bits}
  // ---------------------------------------------------------------------------
`ifdef MULTDIV_BOOTH_EN
  logic [33:0] a_ext, booth_add, booth_sum;

  always_comb begin
    a_ext = {{2{op_q[31]}}, op_q};
    unique case ({prod_q[1:0], booth_q})
      3'b001, 3'b010: booth_add = a_ext;
      3'b011:         booth_add = a_ext << 1;
      3'b100:         booth_add = 34'd0 - (a_ext << 1);
      3'b101, 3'b110: booth_add = 34'd0 - a_ext;
      default:        booth_add = 34'd0;
    endcase
    booth_sum = {{2{prod_q[63]}}, prod_q[63:32]} + booth_add;
    mul_next  = {booth_sum, prod_q[31:2]};
  end
`else
  logic [32:0] mul_add, mul_sum;

  always_comb begin
    mul_add = 33'd0;
    if (prod_q[0]) begin
      // Bit 31 of a two's complement multiplier carries negative weight.
      mul_add = (cnt_q == 6'd31) ? (33'd0 - {op_q[31], op_q}) : {op_q[31], op_q};
    end
    mul_sum  = {prod_q[63], prod_q[63:32]} + mul_add;
    mul_next = {mul_sum, prod_q[31:1]};
  end
`endif

  // ---------------------------------------------------------------------------
  // Restoring divide step: prod_q = {remainder, dividend/quotient}
  // ---------------------------------------------------------------------------
  logic [32:0] div_shift, div_diff;

  always_comb begin
    div_shift = {prod_q[63:32], prod_q[31]};
    div_diff  = div_shift - {1'b0, op_q};
    if (!div_diff[32]) begin
      div_next = {div_diff[31:0], prod_q[30:0], 1'b1};
    end else begin
      div_next = {div_shift[31:0], prod_q[30:0], 1'b0};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_mul) begin
      state_d = StMult;
    end else if (start_div) begin
      state_d = StDiv;
    end else if ((state_q == StMult || state_q == StDiv) && last) begin
      state_d = StDone;
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    op_d     = op_q;
    sign_d   = sign_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    busy_d   = 1'b0;
`ifdef MULTDIV_BOOTH_EN
    booth_d  = booth_q;
`endif
    if (start_mul) begin
      op_d   = data_operandA;
      prod_d = {32'd0, data_operandB};
      sign_d = 1'b0;
      cnt_d  = 6'd0;
      busy_d = 1'b1;
`ifdef MULTDIV_BOOTH_EN
      booth_d = 1'b0;
`endif
    end else if (start_div) begin
      op_d   = abs_b;
      prod_d = {32'd0, abs_a};
      sign_d = data_operandA[31] ^ data_operandB[31];
      cnt_d  = 6'd0;
      busy_d = 1'b1;
    end else begin
      unique case (state_q)
        StMult: begin
          if (!last) begin
            prod_d = mul_next;
            cnt_d  = cnt_q + 6'd1;
            busy_d = 1'b1;
`ifdef MULTDIV_BOOTH_EN
            booth_d = prod_q[1];
`endif
          end else begin
            result_d = prod_q[31:0];
            exc_d    = mul_ovf;
            rdy_d    = 1'b1;
          end
        end
        StDiv: begin
          if (!last) begin
            prod_d = div_next;
            cnt_d  = cnt_q + 6'd1;
            busy_d = 1'b1;
          end else begin
            result_d = div_zero ? 32'd0 : quot_s;
            exc_d    = div_zero | div_ovf;
            rdy_d    = 1'b1;
          end
        end
        StIdle, StDone: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      cnt_q    <= 6'd0;
      prod_q   <= 64'd0;
      op_q     <= 32'd0;
      sign_q   <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MULTDIV_BOOTH_EN
      booth_q  <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
`ifdef MULTDIV_BOOTH_EN
      booth_q  <= booth_d;
`endif
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_iter.sv
// Directed self-checking bench for multdiv_iter; honours MULTDIV_BOOTH_EN for multiply latency.
module tb_multdiv_iter;

`ifdef MULTDIV_BOOTH_EN
  localparam int MulLat = 17;
`else
  localparam int MulLat = 33;
`endif
  localparam int DivLat = 33;

  logic        clock;
  logic        ctrl_reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  multdiv_iter dut (
    .clock          (clock),
    .ctrl_reset     (ctrl_reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start on the next edge, scramble operands while busy, then check timing and result.
  task automatic run_op(input string tag, input logic is_div, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input logic exp_exc);
    int lat;
    int early;
    lat = is_div ? DivLat : MulLat;
    ctrl_MULT     = ~is_div;
    ctrl_DIV      = is_div;
    data_operandA = a;
    data_operandB = b;
    tick();
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = ~a;
    data_operandB = b ^ 32'h5a5a_a5a5;
    early = 0;
    for (int e = 1; e < lat; e++) begin
      tick();
      if (data_resultRDY) early++;
    end
    check({tag, "_early_rdy"}, early, 0);
    check({tag, "_busy"}, busy, 1);
    tick();
    check({tag, "_rdy"}, data_resultRDY, 1);
    check({tag, "_res"}, data_result, exp_res);
    check({tag, "_exc"}, data_exception, exp_exc);
    check({tag, "_idle"}, busy, 0);
    tick();
    check({tag, "_rdy_drop"}, data_resultRDY, 0);
    check({tag, "_hold"}, data_result, exp_res);
  endtask

  initial begin
    int cnt;
    ctrl_reset    = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (3) tick();
    check("rst_res", data_result, 0);
    check("rst_exc", data_exception, 0);
    check("rst_rdy", data_resultRDY, 0);
    check("rst_busy", busy, 0);

    // First edge with reset high must accept the start.
    ctrl_reset = 1'b1;
    run_op("mul_7x-3", 1'b0, 32'd7, 32'hffff_fffd, 32'hffff_ffeb, 1'b0);
    run_op("mul_ovf16", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    run_op("mul_neg_neg", 1'b0, 32'hffff_fff9, 32'hffff_fffd, 32'd21, 1'b0);
    run_op("mul_max", 1'b0, 32'h7fff_ffff, 32'h7fff_ffff, 32'h0000_0001, 1'b1);
    run_op("mul_min_x1", 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    run_op("mul_min_xm1", 1'b0, 32'hffff_ffff, 32'h8000_0000, 32'h8000_0000, 1'b1);
    run_op("div_-100_7", 1'b1, 32'hffff_ff9c, 32'd7, 32'hffff_fff2, 1'b0);
    run_op("div_5_0", 1'b1, 32'd5, 32'd0, 32'd0, 1'b1);
    run_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1'b1);
    run_op("div_7_-2", 1'b1, 32'd7, 32'hffff_fffe, 32'hffff_fffd, 1'b0);
    run_op("div_-7_-2", 1'b1, 32'hffff_fff9, 32'hffff_fffe, 32'd3, 1'b0);
    run_op("div_min_1", 1'b1, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);

    // Both pulses in DONE: ignored, result held.
    ctrl_MULT     = 1'b1;
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd9;
    data_operandB = 32'd9;
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    check("both_done_busy", busy, 0);
    check("both_done_res", data_result, 32'h8000_0000);
    tick();
    check("both_done_rdy", data_resultRDY, 0);

    // Abort: MULT, then DIV 20/4 at edge 10.
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd3;
    data_operandB = 32'd5;
    tick();
    ctrl_MULT = 1'b0;
    cnt = 0;
    for (int e = 1; e < 10; e++) begin
      tick();
      if (data_resultRDY) cnt++;
    end
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd20;
    data_operandB = 32'd4;
    tick();
    ctrl_DIV = 1'b0;
    for (int e = 1; e < DivLat; e++) begin
      tick();
      if (data_resultRDY) cnt++;
    end
    check("abort_no_rdy", cnt, 0);
    tick();
    check("abort_rdy", data_resultRDY, 1);
    check("abort_res", data_result, 32'd5);
    check("abort_exc", data_exception, 0);

    // Reset at edge 15 of a multiply.
    ctrl_MULT     = 1'b1;
    data_operandA = 32'h0000_1234;
    data_operandB = 32'h0000_0010;
    tick();
    ctrl_MULT = 1'b0;
    for (int e = 1; e < 15; e++) tick();
    ctrl_reset = 1'b0;
    tick();
    check("midrst_res", data_result, 0);
    check("midrst_exc", data_exception, 0);
    check("midrst_rdy", data_resultRDY, 0);
    check("midrst_busy", busy, 0);
    ctrl_MULT = 1'b1;
    tick();
    check("rst_prio_busy", busy, 0);

    // Both pulses from IDLE: no start.
    ctrl_reset = 1'b1;
    ctrl_DIV   = 1'b1;
    tick();
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    check("both_idle_busy", busy, 0);
    cnt = 0;
    for (int e = 0; e < 40; e++) begin
      tick();
      if (data_resultRDY || busy) cnt++;
    end
    check("both_idle_quiet", cnt, 0);
    check("both_idle_res", data_result, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multdiv_iter.md
MULTDIV_ITER -- requirements
Module: multdiv_iter

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), one clock domain, all outputs registered:
- clock  in  1  single clock; all state updates on rising edge.
- ctrl_reset  in  1  synchronous, active-low reset.
- ctrl_MULT  in  1  one-cycle start pulse, signed multiply.
- ctrl_DIV  in  1  one-cycle start pulse, signed divide.
- data_operandA  in  32  multiplicand / dividend, two's complement, sampled only on a start edge.
- data_operandB  in  32  multiplier / divisor, two's complement, sampled only on a start edge.
- data_result  out  32  low 32 bits of product, or quotient.
- data_exception  out  1  overflow / divide-by-zero flag, valid with data_result.
- data_resultRDY  out  1  one-cycle strobe; downstream falling-edge result register uses it as write enable.
- busy  out  1  high while an operation is in progress.

Function
REQ-002 FSM states SHALL be IDLE, MULT, DIV, DONE; reset state is IDLE.
REQ-003 IDLE/DONE: on an edge with exactly one of ctrl_MULT, ctrl_DIV high, the block SHALL capture both operands, clear the iteration counter, and enter MULT or DIV respectively.
REQ-004 Both start pulses high on the same edge SHALL be ignored: no state change, outputs held.
REQ-005 A start pulse in MULT or DIV SHALL abort the current operation and restart with the new operands; the aborted operation produces no data_resultRDY.
REQ-006 MULT SHALL be iterative shift-add on a 64-bit product register, 32 iterations, one per cycle.
REQ-007 DIV SHALL be restoring division on magnitudes, 32 iterations, one per cycle; quotient sign = signA XOR signB; truncation toward zero; remainder discarded.
REQ-008 Latency: data_resultRDY SHALL be high for exactly the cycle following the 33rd rising edge after the start edge (start edge = edge 0), then DONE; busy high from edge 1 through edge 33 inclusive.
REQ-009 DONE SHALL hold data_result and data_exception stable until the next accepted start; data_resultRDY low in DONE.
REQ-010 Multiply exception SHALL be 1 when the 64-bit signed product is not representable in 32 signed bits (upper 33 bits not all equal); data_result = low 32 bits regardless.
REQ-011 Divide by zero SHALL complete with normal latency, data_result = 0, data_exception = 1.
REQ-012 Divide 0x80000000 by 0xFFFFFFFF SHALL return data_result = 0x80000000, data_exception = 1.
REQ-013 Operand changes while busy SHALL NOT affect the running operation.
REQ-014 The 6-bit iteration counter SHALL NOT wrap; it saturates at the terminal count until the next start.

Reset
REQ-015 ctrl_reset low at a rising edge SHALL force IDLE, data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0, and clear the counter and internal registers.
REQ-016 Reset mid-operation SHALL abort with no data_resultRDY; reset SHALL take priority over simultaneous start pulses.
REQ-017 The first start SHALL be accepted on the first edge with ctrl_reset high.

Configuration
REQ-018 Macro MULTDIV_BOOTH_EN, when defined, SHALL replace the shift-add multiply with radix-4 Booth recoding: 16 iterations, data_resultRDY in the cycle after edge 17, busy edges 1-17; results and exceptions identical to REQ-010.
REQ-019 Without MULTDIV_BOOTH_EN, multiply SHALL follow REQ-006/REQ-008; divide latency is 33 in both builds.

Verification
REQ-020 MULT 7 x -3 -> after 33 edges (17 with Booth) RDY one cycle, result 0xFFFFFFEB, exception 0.
REQ-021 MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1.
REQ-022 DIV -100 / 7 -> result 0xFFFFFFF2 (-14), exception 0, RDY at edge 33; DIV 5 / 0 -> result 0, exception 1.
REQ-023 DIV 0x80000000 / -1 -> result 0x80000000, exception 1.
REQ-024 MULT start, then DIV 20 / 4 pulse at edge 10 -> no RDY for the multiply; RDY 33 edges after edge 10 with result 5.
REQ-025 Reset low at edge 15 of a MULT -> all outputs 0 next cycle, no RDY; ctrl_MULT and ctrl_DIV high together -> no start, busy stays 0.
